// File: rtl/regfile_operand_fetch.sv
// regfile_operand_fetch: two-source operand fetch sequencer for a 16 x 18-bit register file,
// with same-edge writeback forwarding and writeback pass-through to the register file.
// Ports:
//   clock, reset_n                       clock and asynchronous active-low reset
//   req_valid/req_ready, req_src1/2      read request handshake and source indices
//   wb_valid, wb_reg, wb_data            writeback, always accepted
//   op_valid/op_ready, op_a/op_b         operand handshake to execute stage
//   rf_reg_to_read1/2, rf_data_to_read1/2  register file read side (data registered)
//   rf_reg_to_write, rf_data_to_write    register file write side
//   rf_enable, rf_load                   register file enable and write strobe
module regfile_operand_fetch #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_src1,
    input  logic [ADDR_WIDTH-1:0] req_src2,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_reg,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic [ADDR_WIDTH-1:0] rf_reg_to_read1,
    output logic [ADDR_WIDTH-1:0] rf_reg_to_read2,
    output logic [ADDR_WIDTH-1:0] rf_reg_to_write,
    output logic [DATA_WIDTH-1:0] rf_data_to_write,
    output logic                  rf_enable,
    output logic                  rf_load,
    input  logic [DATA_WIDTH-1:0] rf_data_to_read1,
    input  logic [DATA_WIDTH-1:0] rf_data_to_read2
);
    typedef enum logic [1:0] {IDLE, READ, CAPTURE, VALID} state_t;
    state_t state, state_next;
    logic [ADDR_WIDTH-1:0] src1, src2;
    logic fwd1, fwd2;
    logic [DATA_WIDTH-1:0] fwd_data1, fwd_data2;
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = req_valid ? READ : IDLE;
            READ:    state_next = CAPTURE;
            CAPTURE: state_next = VALID;
            VALID:   state_next = op_ready ? IDLE : VALID;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            src1      <= '0;
            src2      <= '0;
            fwd1      <= 1'b0;
            fwd2      <= 1'b0;
            fwd_data1 <= '0;
            fwd_data2 <= '0;
            op_a      <= '0;
            op_b      <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                src1 <= req_src1;
                src2 <= req_src2;
            end
            // The register file returns pre-write contents for a write on the
            // read edge, so a matching writeback is captured here instead.
            if (state == READ) begin
                fwd1      <= wb_valid && wb_reg == src1;
                fwd2      <= wb_valid && wb_reg == src2;
                fwd_data1 <= wb_data;
                fwd_data2 <= wb_data;
            end
            if (state == CAPTURE) begin
                op_a <= fwd1 ? fwd_data1 : rf_data_to_read1;
                op_b <= fwd2 ? fwd_data2 : rf_data_to_read2;
                fwd1 <= 1'b0;
                fwd2 <= 1'b0;
            end
        end
    end
    // Combinational outputs are gated by reset_n so they read zero while reset is held.
    assign req_ready        = reset_n && state == IDLE;
    assign op_valid         = state == VALID;
    assign rf_reg_to_read1  = src1;
    assign rf_reg_to_read2  = src2;
    assign rf_reg_to_write  = reset_n ? wb_reg : '0;
    assign rf_data_to_write = reset_n ? wb_data : '0;
    assign rf_load          = reset_n && wb_valid;
    assign rf_enable        = reset_n && (state == READ || wb_valid);
endmodule

// File: tb/tb_regfile_operand_fetch.sv
// tb_regfile_operand_fetch: directed self-checking bench with a behavioural register file.
module tb_regfile_operand_fetch;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic req_valid = 1'b0, req_ready;
    logic [3:0] req_src1 = '0, req_src2 = '0;
    logic wb_valid = 1'b0;
    logic [3:0] wb_reg = '0;
    logic [17:0] wb_data = '0;
    logic op_valid, op_ready = 1'b0;
    logic [17:0] op_a, op_b;
    logic [3:0] rf_reg_to_read1, rf_reg_to_read2, rf_reg_to_write;
    logic [17:0] rf_data_to_write, rf_data_to_read1, rf_data_to_read2;
    logic rf_enable, rf_load;
    logic [17:0] mem [16];
    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    regfile_operand_fetch dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_src1(req_src1), .req_src2(req_src2),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .rf_reg_to_read1(rf_reg_to_read1), .rf_reg_to_read2(rf_reg_to_read2),
        .rf_reg_to_write(rf_reg_to_write), .rf_data_to_write(rf_data_to_write),
        .rf_enable(rf_enable), .rf_load(rf_load),
        .rf_data_to_read1(rf_data_to_read1), .rf_data_to_read2(rf_data_to_read2)
    );

    // Register file: registered reads return contents from before a same-edge write.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rf_data_to_read1 = '0;
        rf_data_to_read2 = '0;
    end
    always @(posedge clock) begin
        if (rf_enable) begin
            rf_data_to_read1 <= mem[rf_reg_to_read1];
            rf_data_to_read2 <= mem[rf_reg_to_read2];
            if (rf_load) mem[rf_reg_to_write] <= rf_data_to_write;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wb_write(input logic [3:0] r, input logic [17:0] d);
        wb_valid = 1'b1;
        wb_reg = r;
        wb_data = d;
        tick();
        wb_valid = 1'b0;
    endtask

    // Issue a request from IDLE; returns in the READ cycle.
    task automatic request(input logic [3:0] s1, input logic [3:0] s2);
        req_valid = 1'b1;
        req_src1 = s1;
        req_src2 = s2;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [17:0] ea, input logic [17:0] eb);
        op_ready = 1'b1;
        request(s1, s2);
        tick();
        tick();
        check({tag, "_valid"}, op_valid, 1);
        check({tag, "_a"}, op_a, ea);
        check({tag, "_b"}, op_b, eb);
        tick();
        check({tag, "_idle"}, req_ready, 1);
    endtask

    initial begin
        logic hit_acc, hit_op;
        int n_acc, n_op;
        int acc_cyc [2];
        logic [17:0] got_a [2], got_b [2];
        wb_valid = 1'b1;
        wb_reg = 4'd5;
        wb_data = 18'h1234;
        repeat (2) tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_op_a", op_a, 0);
        check("rst_rf_enable", rf_enable, 0);
        check("rst_rf_load", rf_load, 0);
        check("rst_rd1", rf_reg_to_read1, 0);
        wb_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        check("idle_ready", req_ready, 1);

        // basic read
        wb_write(4'd3, 18'h00005);
        wb_write(4'd7, 18'h3FFFF);
        op_ready = 1'b1;
        request(4'd3, 4'd7);
        check("read_idx1", rf_reg_to_read1, 3);
        check("read_idx2", rf_reg_to_read2, 7);
        check("read_en", rf_enable, 1);
        check("read_ready", req_ready, 0);
        check("read_valid", op_valid, 0);
        tick();
        check("cap_valid", op_valid, 0);
        check("cap_en", rf_enable, 0);
        tick();
        check("basic_valid", op_valid, 1);
        check("basic_a", op_a, 18'h00005);
        check("basic_b", op_b, 18'h3FFFF);
        tick();
        check("basic_ready", req_ready, 1);
        check("basic_drop", op_valid, 0);

        // same-edge forward
        wb_write(4'd2, 18'h00011);
        request(4'd2, 4'd2);
        wb_valid = 1'b1;
        wb_reg = 4'd2;
        wb_data = 18'h00022;
        #1;
        check("fwd_load", rf_load, 1);
        tick();
        wb_valid = 1'b0;
        tick();
        check("fwd_a", op_a, 18'h00022);
        check("fwd_b", op_b, 18'h00022);
        tick();

        // late write in CAPTURE
        wb_write(4'd4, 18'h00100);
        request(4'd4, 4'd3);
        tick();
        wb_valid = 1'b1;
        wb_reg = 4'd4;
        wb_data = 18'h00200;
        tick();
        wb_valid = 1'b0;
        check("late_a", op_a, 18'h00100);
        check("late_b", op_b, 18'h00005);
        tick();
        fetch("late_next", 4'd4, 4'd7, 18'h00200, 18'h3FFFF);

        // unrelated write in READ must not forward
        request(4'd3, 4'd7);
        wb_valid = 1'b1;
        wb_reg = 4'd8;
        wb_data = 18'h0BEEF;
        tick();
        wb_valid = 1'b0;
        tick();
        check("nofwd_a", op_a, 18'h00005);
        check("nofwd_b", op_b, 18'h3FFFF);
        tick();

        // backpressure
        op_ready = 1'b0;
        request(4'd7, 4'd3);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                wb_valid = 1'b1;
                wb_reg = 4'd9;
                wb_data = 18'h00ABC;
                #1;
                check("bp_load", rf_load, 1);
                check("bp_en", rf_enable, 1);
            end
            check("bp_valid", op_valid, 1);
            check("bp_ready", req_ready, 0);
            check("bp_a", op_a, 18'h3FFFF);
            check("bp_b", op_b, 18'h00005);
            tick();
            wb_valid = 1'b0;
        end
        op_ready = 1'b1;
        tick();
        check("bp_release", req_ready, 1);

        // reset mid-operation (during CAPTURE)
        request(4'd3, 4'd7);
        tick();
        wb_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        check("mrst_valid", op_valid, 0);
        check("mrst_en", rf_enable, 0);
        check("mrst_load", rf_load, 0);
        check("mrst_rd1", rf_reg_to_read1, 0);
        check("mrst_wr", rf_reg_to_write, 0);
        check("mrst_ready", req_ready, 0);
        tick();
        tick();
        check("mrst_hold", op_valid, 0);
        wb_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        fetch("post_rst", 4'd3, 4'd9, 18'h00005, 18'h00ABC);

        // back-to-back requests
        wb_write(4'd1, 18'h00111);
        wb_write(4'd2, 18'h00222);
        wb_write(4'd4, 18'h00444);
        op_ready = 1'b1;
        req_valid = 1'b1;
        req_src1 = 4'd1;
        req_src2 = 4'd2;
        n_acc = 0;
        n_op = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        for (int c = 0; c < 20 && n_op < 2; c++) begin
            hit_acc = req_valid && req_ready;
            hit_op = op_valid && op_ready;
            if (hit_op) begin
                got_a[n_op] = op_a;
                got_b[n_op] = op_b;
                n_op++;
            end
            tick();
            if (hit_acc) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                req_src1 = 4'd3;
                req_src2 = 4'd4;
                if (n_acc == 2) req_valid = 1'b0;
            end
        end
        check("b2b_ops", n_op, 2);
        check("b2b_accs", n_acc, 2);
        check("b2b_gap", acc_cyc[1] - acc_cyc[0], 4);
        if (n_op == 2) begin
            check("b2b_a0", got_a[0], 18'h00111);
            check("b2b_b0", got_b[0], 18'h00222);
            check("b2b_a1", got_a[1], 18'h00005);
            check("b2b_b1", got_b[1], 18'h00444);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
